// File: rtl/inst_loader.sv
// inst_loader: gathers NUM_WORDS program words from a valid/ready stream into a flat image, then strobes load_pulse.
// Optional build macro INST_LOADER_CHECKSUM_EN adds a trailing XOR checksum word and an ERROR state.
module inst_loader #(
    parameter int NUM_WORDS    = 16,
    parameter int WORD_W       = 32,
    parameter int PULSE_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               wr_valid,
    input  logic [WORD_W-1:0]                  wr_data,
    output logic                               wr_ready,
    output logic [WORD_W*NUM_WORDS-1:0]        load_mem,
    output logic                               load_pulse,
    output logic [$clog2(NUM_WORDS+2)-1:0]     word_cnt,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);
    localparam int CW = $clog2(NUM_WORDS + 2);
    localparam int PW = $clog2(PULSE_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_PULSE   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
`ifdef INST_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_ERROR   = 3'd5;
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_WORDS);
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_WORDS - 1);
`endif

    logic [2:0]        state;
    logic [PW-1:0]     pulse_cnt;
    logic              xfer;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] csum;
`else
    assign err = 1'b0;
`endif

    assign wr_ready = (state == S_COLLECT);
    assign busy     = (state == S_COLLECT) || (state == S_SETTLE) || (state == S_PULSE);
    // abort outranks a word presented in the same cycle
    assign xfer     = wr_valid && wr_ready && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            load_mem   <= '0;
            load_pulse <= 1'b0;
            word_cnt   <= '0;
            pulse_cnt  <= '0;
            done       <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            err        <= 1'b0;
            csum       <= '0;
`endif
        end else begin
            case (state)
                S_COLLECT: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (xfer) begin
                        // the checksum word (index NUM_WORDS) matches no slot and is never stored
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            if (word_cnt == CW'(i)) load_mem[i*WORD_W +: WORD_W] <= wr_data;
                        end
                        word_cnt <= word_cnt + 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                        csum <= csum ^ wr_data;
                        if (word_cnt == LAST_CNT) begin
                            if (wr_data == csum) begin
                                state <= S_SETTLE;
                            end else begin
                                state <= S_ERROR;
                                err   <= 1'b1;
                            end
                        end
`else
                        if (word_cnt == LAST_CNT) state <= S_SETTLE;
`endif
                    end
                end
                S_SETTLE: begin
                    state     <= S_PULSE;
                    pulse_cnt <= '0;
                end
                // first PULSE cycle registers the strobe; it then stays high PULSE_CYCLES cycles
                S_PULSE: begin
                    if (pulse_cnt == PW'(PULSE_CYCLES)) begin
                        state      <= S_DONE;
                        load_pulse <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        load_pulse <= 1'b1;
                        pulse_cnt  <= pulse_cnt + 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state    <= S_COLLECT;
                        word_cnt <= '0;
                        done     <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
                        err      <= 1'b0;
                        csum     <= '0;
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: randomized word streams checked against an array image model
// and a cycle-exact pulse window derived from the final accepted word.
module tb_inst_loader;
    localparam int NW = 16;
    localparam int WW = 32;
    localparam int PC = 2;
    localparam int CW = $clog2(NW + 2);
`ifdef INST_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int NSEND = NW + CS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              wr_valid = 1'b0;
    logic [WW-1:0]     wr_data = '0;
    logic              wr_ready;
    logic [WW*NW-1:0]  load_mem;
    logic              load_pulse;
    logic [CW-1:0]     word_cnt;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    logic [WW-1:0] exp_mem [NW];
    logic [WW-1:0] stim [NSEND];
    logic [WW-1:0] exp_q [$];

    inst_loader #(.NUM_WORDS(NW), .WORD_W(WW), .PULSE_CYCLES(PC)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .load_mem(load_mem), .load_pulse(load_pulse), .word_cnt(word_cnt),
        .busy(busy), .done(done), .err(err)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // stimulus: mode 0 -> word i, 1 -> random; a good checksum is appended when enabled
    task automatic fill_stim(input int mode);
        logic [WW-1:0] x;
        x = '0;
        for (int i = 0; i < NW; i++) begin
            stim[i] = (mode == 0) ? WW'(i) : $urandom;
            x ^= stim[i];
        end
        if (CS == 1) stim[NSEND-1] = x;
    endtask

    task automatic drain_model();
        int j;
        j = 0;
        while (exp_q.size() > 0) begin
            logic [WW-1:0] w;
            w = exp_q.pop_front();
            if (j < NW) exp_mem[j] = w;
            j++;
        end
    endtask

    task automatic check_image(input string tag);
        for (int i = 0; i < NW; i++) begin
            n_checks++;
            if (load_mem[i*WW +: WW] !== exp_mem[i]) begin
                $display("FAIL %s slot %0d: got %h expected %h", tag, i, load_mem[i*WW +: WW], exp_mem[i]);
                n_errors++;
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || word_cnt !== '0 || done !== 1'b0 || err !== 1'b0) begin
            $display("FAIL start_entry: busy=%b cnt=%0d done=%b err=%b expected 1 0 0 0", busy, word_cnt, done, err);
            n_errors++;
        end
    endtask

    // driver: sends nwords from stim; gap 0 continuous, 1 every other cycle, 2 random
    task automatic collect(input int gap, input int nwords, input bit poke_start);
        int acc;
        int cyc;
        acc = 0;
        cyc = 0;
        while (acc < nwords && cyc < 400) begin
            case (gap)
                0:       wr_valid = 1'b1;
                1:       wr_valid = (cyc % 2 == 0);
                default: wr_valid = ($urandom_range(0, 3) != 0);
            endcase
            wr_data = wr_valid ? stim[acc] : $urandom;
            start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
            n_checks++;
            if (wr_ready !== 1'b1) begin
                $display("FAIL ready_in_collect word %0d: got %b expected 1", acc, wr_ready);
                n_errors++;
            end
            tick();
            if (wr_valid) begin
                exp_q.push_back(stim[acc]);
                acc++;
            end
            start = 1'b0;
            n_checks++;
            if (word_cnt !== CW'(acc)) begin
                $display("FAIL word_cnt cycle %0d: got %0d expected %0d", cyc, word_cnt, acc);
                n_errors++;
            end
            n_checks++;
            if (load_pulse !== 1'b0) begin
                $display("FAIL early_pulse cycle %0d: got %b expected 0", cyc, load_pulse);
                n_errors++;
            end
            cyc++;
        end
        wr_valid = 1'b0;
        drain_model();
    endtask

    // called at final-transfer edge + 1: strobe high for edges E+2 .. E+1+PC
    task automatic check_pulse(input bit poke_start);
        for (int k = 1; k <= PC + 2; k++) begin
            start = poke_start && (k <= PC + 1);
            tick();
            n_checks++;
            if (load_pulse !== ((k >= 2 && k <= PC + 1) ? 1'b1 : 1'b0)) begin
                $display("FAIL pulse_window E+%0d: got %b expected %b", k, load_pulse, (k >= 2 && k <= PC + 1));
                n_errors++;
            end
            n_checks++;
            if (busy !== ((k <= PC + 1) ? 1'b1 : 1'b0) || done !== ((k == PC + 2) ? 1'b1 : 1'b0)) begin
                $display("FAIL busy_done E+%0d: busy=%b done=%b expected %b %b", k, busy, done, (k <= PC + 1), (k == PC + 2));
                n_errors++;
            end
        end
        start = 1'b0;
        n_checks++;
        if (word_cnt !== CW'(NSEND) || err !== 1'b0 || wr_ready !== 1'b0) begin
            $display("FAIL done_state: cnt=%0d err=%b ready=%b expected %0d 0 0", word_cnt, err, wr_ready, NSEND);
            n_errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < NW; i++) exp_mem[i] = '0;
        n_checks++;
        if (load_pulse !== 1'b0 || wr_ready !== 1'b0 || word_cnt !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            $display("FAIL reset_outputs: pulse=%b ready=%b cnt=%0d busy=%b done=%b err=%b expected all 0",
                     load_pulse, wr_ready, word_cnt, busy, done, err);
            n_errors++;
        end
        check_image("reset_image");
    endtask

    task automatic test_basic_stream();
        fill_stim(0);
        do_start();
        collect(0, NSEND, 1'b0);
        check_pulse(1'b0);
        check_image("basic_image");
    endtask

    task automatic test_valid_toggle();
        fill_stim(1);
        do_start();
        collect(1, NSEND, 1'b0);
        check_pulse(1'b0);
        check_image("toggle_image");
    endtask

    task automatic test_abort();
        fill_stim(1);
        do_start();
        collect(2, 5, 1'b0);
        abort = 1'b1;
        wr_valid = 1'b1;
        wr_data = stim[5];
        tick();
        abort = 1'b0;
        wr_valid = 1'b0;
        n_checks++;
        if (word_cnt !== CW'(5) || busy !== 1'b0 || wr_ready !== 1'b0 || done !== 1'b0) begin
            $display("FAIL abort_state: cnt=%0d busy=%b ready=%b done=%b expected 5 0 0 0", word_cnt, busy, wr_ready, done);
            n_errors++;
        end
        check_image("abort_image");
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (load_pulse !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL abort_no_pulse cycle %0d: pulse=%b busy=%b expected 0 0", k, load_pulse, busy);
                n_errors++;
            end
        end
        fill_stim(1);
        do_start();
        collect(0, NSEND, 1'b0);
        check_pulse(1'b0);
        check_image("reload_image");
    endtask

    task automatic test_reset_mid_pulse();
        fill_stim(1);
        do_start();
        collect(0, NSEND, 1'b0);
        tick();
        tick();
        tick();
        n_checks++;
        if (load_pulse !== 1'b1) begin
            $display("FAIL second_pulse_cycle: got %b expected 1", load_pulse);
            n_errors++;
        end
        rst = 1'b1;
        wr_valid = 1'b1;
        wr_data = $urandom;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NW; i++) exp_mem[i] = '0;
        n_checks++;
        if (load_pulse !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_mid_pulse: pulse=%b done=%b busy=%b expected 0 0 0", load_pulse, done, busy);
            n_errors++;
        end
        check_image("reset_mid_pulse_image");
        for (int k = 0; k < 4; k++) begin
            wr_data = $urandom;
            tick();
            n_checks++;
            if (wr_ready !== 1'b0 || word_cnt !== '0 || load_pulse !== 1'b0) begin
                $display("FAIL idle_ignores_valid cycle %0d: ready=%b cnt=%0d pulse=%b expected 0 0 0", k, wr_ready, word_cnt, load_pulse);
                n_errors++;
            end
        end
        wr_valid = 1'b0;
        check_image("idle_image");
    endtask

    task automatic test_ignored_inputs();
        fill_stim(1);
        do_start();
        collect(2, NSEND, 1'b1);
        check_pulse(1'b1);
        wr_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_data = $urandom;
            tick();
            n_checks++;
            if (word_cnt !== CW'(NSEND) || done !== 1'b1 || busy !== 1'b0 || load_pulse !== 1'b0) begin
                $display("FAIL done_ignores_valid cycle %0d: cnt=%0d done=%b busy=%b pulse=%b expected %0d 1 0 0",
                         k, word_cnt, done, busy, load_pulse, NSEND);
                n_errors++;
            end
        end
        wr_valid = 1'b0;
        check_image("ignored_image");
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 3; s++) begin
            fill_stim(1);
            do_start();
            collect(s % 3, NSEND, 1'b0);
            check_pulse(1'b0);
            check_image("b2b_image");
        end
    endtask

`ifdef INST_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int i = 0; i < NW; i++) stim[i] = WW'(i + 1);
        stim[NW] = 32'h0000_0010;
        do_start();
        collect(0, NSEND, 1'b0);
        check_pulse(1'b0);
        check_image("csum_good_image");
        stim[NW] = 32'h0;
        do_start();
        collect(0, NSEND, 1'b0);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || load_pulse !== 1'b0 || wr_ready !== 1'b0) begin
                $display("FAIL csum_error cycle %0d: err=%b busy=%b done=%b pulse=%b ready=%b expected 1 0 0 0 0",
                         k, err, busy, done, load_pulse, wr_ready);
                n_errors++;
            end
            tick();
        end
        do_start();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_stream();
        test_valid_toggle();
        test_abort();
        test_reset_mid_pulse();
        test_ignored_inputs();
        test_back_to_back();
`ifdef INST_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
